// File: rtl/prio_enc_arb.sv
// prio_enc_arb: sticky request accumulator with priority select and a one-deep valid/ready grant stage.
// Build option PRIO_ENC_ARB_RR_EN switches the fixed highest-index priority to a rotating search pointer.
module prio_enc_arb #(
   parameter  int WIDTH = 8,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] pending,
   output logic             none_pending,
   output logic             dup_err
);

   logic [WIDTH-1:0] r_pending;
   logic             r_out_valid;
   logic [IDX_W-1:0] r_out_idx;
   logic             r_dup_err;

   logic             w_load;
   logic             w_any;
   logic             w_capture;
   logic [IDX_W-1:0] w_sel;
   logic [WIDTH-1:0] w_clr;
   logic             w_dup;

   assign w_load    = !r_out_valid || out_ready;
   assign w_any     = |r_pending;
   assign w_capture = w_load && w_any;

`ifdef PRIO_ENC_ARB_RR_EN
   logic [IDX_W-1:0] r_ptr;

   // Descending search from r_ptr with wrap-around; first hit wins.
   always_comb begin : p_sel
      int   v_j;
      logic v_found;
      v_j     = 0;
      v_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < WIDTH; k++) begin
         v_j = int'(r_ptr) - k;
         if (v_j < 0) v_j = v_j + WIDTH;
         if (!v_found && r_pending[IDX_W'(v_j)]) begin
            w_sel   = IDX_W'(v_j);
            v_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= IDX_W'(WIDTH - 1);
      end else if (w_capture) begin
         r_ptr <= (w_sel == '0) ? IDX_W'(WIDTH - 1) : w_sel - 1'b1;
      end
   end
`else
   // Ascending scan so the highest set index is the last assignment.
   always_comb begin : p_sel
      w_sel = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (r_pending[i]) w_sel = IDX_W'(i);
      end
   end
`endif

   assign w_clr = w_capture ? (WIDTH'(1) << w_sel) : '0;
   // A re-request of the bit being granted this cycle is a fresh request, not a duplicate.
   assign w_dup = |(req & r_pending & ~w_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_dup_err   <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | req;
         if (w_dup) r_dup_err <= 1'b1;
         if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) r_out_idx <= w_sel;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_idx      = r_out_idx;
   assign pending      = r_pending;
   assign dup_err      = r_dup_err;
   assign none_pending = !w_any && !r_out_valid;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Self-checking bench for prio_enc_arb: hand-computed vector table plus a model-driven random run,
// both feeding an expected-result queue compared one cycle after each stimulus.
module tb_prio_enc_arb;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] req;
   logic         out_ready;
   logic         out_valid;
   logic [2:0]   out_idx;
   logic [W-1:0] pending;
   logic         none_pending;
   logic         dup_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prio_enc_arb #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_idx      (out_idx),
      .pending      (pending),
      .none_pending (none_pending),
      .dup_err      (dup_err)
   );

   typedef struct {
      logic         valid;
      logic [2:0]   idx;
      logic [W-1:0] pend;
      logic         dup;
      logic         none;
   } exp_t;

   typedef struct {
      logic         rst;
      logic [W-1:0] req;
      logic         rdy;
      exp_t         e;
   } vec_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   string tag;

   function automatic void add(input logic r, input logic [W-1:0] q, input logic rd,
                               input logic v, input logic [2:0] ix, input logic [W-1:0] p,
                               input logic d, input logic nn);
      vec_t t;
      t.rst = r; t.req = q; t.rdy = rd;
      t.e.valid = v; t.e.idx = ix; t.e.pend = p; t.e.dup = d; t.e.none = nn;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s %s: got %0h expected %0h", tag, name, got, want);
      end
   endtask

   task automatic apply(input logic r, input logic [W-1:0] q, input logic rd, input exp_t e);
      exp_t x;
      rst = r; req = q; out_ready = rd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      chk("out_valid",    int'(out_valid),    int'(x.valid));
      chk("out_idx",      int'(out_idx),      int'(x.idx));
      chk("pending",      int'(pending),      int'(x.pend));
      chk("dup_err",      int'(dup_err),      int'(x.dup));
      chk("none_pending", int'(none_pending), int'(x.none));
   endtask

   // Reference model written directly from the behavioural description.
   logic [W-1:0] m_pend;
   logic         m_valid;
   logic [2:0]   m_idx;
   logic         m_dup;
   logic [2:0]   m_ptr;

   function automatic logic [2:0] pick(input logic [W-1:0] p, input logic [2:0] ptr);
      logic [2:0] c;
`ifdef PRIO_ENC_ARB_RR_EN
      c = ptr;
      for (int n = 0; n < W; n++) begin
         if (p[c]) return c;
         c = (c == 3'd0) ? 3'd7 : c - 3'd1;
      end
      return 3'd0;
`else
      c = ptr;
      for (int n = W - 1; n >= 0; n--) begin
         if (p[n]) return 3'(n);
      end
      return c;
`endif
   endfunction

   task automatic model_step(input logic r, input logic [W-1:0] q, input logic rd, output exp_t e);
      logic [W-1:0] clr;
      logic [2:0]   s;
      clr = '0;
      if (r) begin
         m_pend = '0; m_valid = 1'b0; m_idx = '0; m_dup = 1'b0; m_ptr = 3'd7;
      end else begin
         if (!m_valid || rd) begin
            if (m_pend != '0) begin
               s = pick(m_pend, m_ptr);
               m_idx = s;
               m_valid = 1'b1;
               clr[s] = 1'b1;
               m_ptr = (s == 3'd0) ? 3'd7 : s - 3'd1;
            end else begin
               m_valid = 1'b0;
            end
         end
         if ((q & m_pend & ~clr) != '0) m_dup = 1'b1;
         m_pend = (m_pend & ~clr) | q;
      end
      e.valid = m_valid; e.idx = m_idx; e.pend = m_pend; e.dup = m_dup;
      e.none = (m_pend == '0) && !m_valid;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      logic [2:0] sidx;
      rst = 1'b1; req = '0; out_ready = 1'b1;

      //  rst  req    rdy  valid idx pend   dup none
      add(1, 8'h00, 1,  0, 0, 8'h00, 0, 1);
      add(0, 8'h26, 1,  0, 0, 8'h26, 0, 0);
      add(0, 8'h00, 1,  1, 5, 8'h06, 0, 0);
      add(0, 8'h00, 1,  1, 2, 8'h02, 0, 0);
      add(0, 8'h00, 1,  1, 1, 8'h00, 0, 0);
      add(0, 8'h00, 1,  0, 1, 8'h00, 0, 1);
      add(1, 8'h00, 0,  0, 0, 8'h00, 0, 1);
      add(0, 8'h81, 0,  0, 0, 8'h81, 0, 0);
      add(0, 8'h00, 0,  1, 7, 8'h01, 0, 0);
      add(0, 8'h00, 0,  1, 7, 8'h01, 0, 0);
      add(0, 8'h00, 1,  1, 0, 8'h00, 0, 0);
      add(0, 8'h00, 1,  0, 0, 8'h00, 0, 1);
      add(0, 8'h10, 0,  0, 0, 8'h10, 0, 0);
      add(0, 8'h10, 0,  1, 4, 8'h10, 0, 0);
      add(0, 8'h10, 0,  1, 4, 8'h10, 1, 0);
      add(0, 8'h00, 0,  1, 4, 8'h10, 1, 0);
      add(0, 8'h10, 1,  1, 4, 8'h10, 1, 0);
      add(0, 8'h00, 1,  1, 4, 8'h00, 1, 0);
      add(0, 8'h00, 1,  0, 4, 8'h00, 1, 1);
      add(0, 8'hF0, 0,  0, 4, 8'hF0, 1, 0);
      add(0, 8'h80, 0,  1, 7, 8'hF0, 1, 0);
      add(1, 8'hFF, 0,  0, 0, 8'h00, 0, 1);
      add(0, 8'h00, 1,  0, 0, 8'h00, 0, 1);
      add(0, 8'hFF, 1,  0, 0, 8'hFF, 0, 0);
      for (int k = 0; k < 9; k++) begin
`ifdef PRIO_ENC_ARB_RR_EN
         sidx = 3'((15 - k) % 8);
`else
         sidx = 3'd7;
`endif
         add(0, 8'hFF, 1, 1, sidx, 8'hFF, 1, 0);
      end
      add(1, 8'h00, 1,  0, 0, 8'h00, 0, 1);

      foreach (tbl[i]) begin
         tag = $sformatf("vec%0d", i);
         apply(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].e);
      end

      for (int c = 0; c < 400; c++) begin
         logic         r;
         logic [W-1:0] q;
         logic         rd;
         r  = (c == 0) || ($urandom_range(0, 59) == 0);
         q  = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
         rd = ($urandom_range(0, 3) != 0);
         model_step(r, q, rd, e);
         tag = $sformatf("rnd%0d", c);
         apply(r, q, rd, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
